// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the stopwatch display path.
// Segment vectors are ordered {g,f,e,d,c,b,a}: bit 0 is segment a, bit 6 is segment g.
// All encodings here are active-high; pin polarity is applied at the output register.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b0000000;

    localparam seg7_t SEG_0 = 7'b0111111;
    localparam seg7_t SEG_1 = 7'b0000110;
    localparam seg7_t SEG_2 = 7'b1011011;
    localparam seg7_t SEG_3 = 7'b1001111;
    localparam seg7_t SEG_4 = 7'b1100110;
    localparam seg7_t SEG_5 = 7'b1101101;
    localparam seg7_t SEG_6 = 7'b1111101;
    localparam seg7_t SEG_7 = 7'b0000111;
    localparam seg7_t SEG_8 = 7'b1111111;
    localparam seg7_t SEG_9 = 7'b1101111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder (active-high, {g,f,e,d,c,b,a}).
// Codes 10..15 are not valid BCD and are shown dark rather than as garbage.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output seg7_t      o_seg
);

    // Table lookup of the digit pattern; anything outside 0..9 is blank
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver for the stopwatch digits.
// The digit bus comes from a divided-clock domain, so it is double-sampled and only
// accepted once two consecutive samples agree. A display register sits after that so
// the lap-hold can freeze what is shown while capture keeps running underneath.
// Each idx change is followed by one dark cycle so the previous digit's pattern never
// bleeds onto the next anode.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits_bcd,
    input  logic                      hold,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     dp_pos,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_sync1;
    logic [4*NUM_DIGITS-1:0] r_sync2;
    logic [4*NUM_DIGITS-1:0] r_stable;
    logic [4*NUM_DIGITS-1:0] r_display;
    logic [PRE_W-1:0]        r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_dead;

    logic [3:0]              w_digit;
    seg7_t                   w_decoded;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [NUM_DIGITS-1:0]   w_an;
    seg7_t                   w_seg;
    logic                    w_dp;

    // Sample the async digit bus twice, accept only when two samples match, then
    // copy into the display register unless the lap-hold is freezing it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_display <= '0;
        end else begin
            r_sync1 <= digits_bcd;
            r_sync2 <= r_sync1;
            if (r_sync1 == r_sync2) begin
                r_stable <= r_sync1;
            end
            if (!hold) begin
                r_display <= r_stable;
            end
        end
    end

    // Prescaler sets the per-digit dwell; its wrap steps idx and opens a dead cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_dead  <= 1'b0;
        end else if (r_presc == PRE_LAST) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            r_dead  <= 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_dead  <= 1'b0;
        end
    end

    // Walk down from the top digit: stay in the leading-zero run until a non-zero
    // digit or a lit decimal point is met; digit 0 is never part of the run
    always_comb begin
        logic w_lead;
        w_lead  = blank_lz;
        w_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if ((r_display[4*k +: 4] != 4'd0) || dp_pos[k]) begin
                w_lead = 1'b0;
            end
            w_blank[k] = w_lead;
        end
    end

    assign w_digit = r_display[{r_idx, 2'b00} +: 4];

    bcd_to_seg7 u_decode (
        .i_bcd (w_digit),
        .o_seg (w_decoded)
    );

    // Active-high drive for the current digit, all dark during the dead cycle
    always_comb begin
        w_an  = '0;
        w_seg = SEG_BLANK;
        w_dp  = 1'b0;
        if (!r_dead) begin
            w_an[r_idx] = 1'b1;
            w_seg       = w_blank[r_idx] ? SEG_BLANK : w_decoded;
            w_dp        = dp_pos[r_idx];
        end
    end

    // Pin register: applies board polarity; frame_start marks the dark cycle before digit 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an          <= {NUM_DIGITS{ACTIVE_LOW}};
            seg         <= {7{ACTIVE_LOW}};
            dp          <= ACTIVE_LOW;
            frame_start <= 1'b0;
        end else begin
            an          <= w_an ^ {NUM_DIGITS{ACTIVE_LOW}};
            seg         <= w_seg ^ {7{ACTIVE_LOW}};
            dp          <= w_dp ^ ACTIVE_LOW;
            frame_start <= r_dead && (r_idx == '0);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4. Two instances share the
// inputs: one active-low, one active-high. Expected pins come from a model that works
// out the scan position from the number of clock edges since reset release.
module tb_seg7_scan_driver;

    localparam logic [12:0] RESET_LOW = 13'b1111_1111111_1_0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_bcd = 16'h0000;
    logic        hold = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_pos = 4'b0000;

    logic [3:0]  anL, anH;
    logic [6:0]  segL, segH;
    logic        dpL, dpH, fsL, fsH;

    int          edges = 0;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] curV = 16'h0000;

    logic [6:0] segTab [0:15] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                  7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
                                  7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dutLow (
        .clk(clk), .reset(reset), .digits_bcd(digits_bcd), .hold(hold),
        .blank_lz(blank_lz), .dp_pos(dp_pos),
        .an(anL), .seg(segL), .dp(dpL), .frame_start(fsL)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dutHigh (
        .clk(clk), .reset(reset), .digits_bcd(digits_bcd), .hold(hold),
        .blank_lz(blank_lz), .dp_pos(dp_pos),
        .an(anH), .seg(segH), .dp(dpH), .frame_start(fsH)
    );

    always #5 clk = ~clk;

    // Count rising edges since reset release; the model derives scan position from it
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    // Active-high {an[3:0], seg[6:0], dp, frame_start} on the pins after e edges.
    // Pins lag the scan position by one edge; each 4-edge slot after the first
    // opens with one dark edge, and the dark edge ahead of digit 0 is the frame pulse.
    function automatic logic [12:0] model_pins(int e, logic [15:0] val, logic blz, logic [3:0] dpp);
        int   k, slot, idx;
        logic lead;
        logic [6:0] s;
        if (e <= 0) return 13'b0;
        k    = e - 1;
        slot = k / 4;
        idx  = slot % 4;
        if (slot > 0 && (k % 4) == 0) return {12'b0, (idx == 0)};
        s    = segTab[val[4*idx +: 4]];
        lead = blz && (idx > 0);
        for (int j = idx; j < 4; j++) begin
            if (val[4*j +: 4] != 4'd0 || dpp[j]) lead = 1'b0;
        end
        if (lead) s = 7'b0;
        return {4'b0001 << idx, s, dpp[idx], 1'b0};
    endfunction

    task automatic test_reset();
        logic [12:0] ex;
        int pulsesL, pulsesH;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks += 2;
            if ({anL, segL, dpL, fsL} !== RESET_LOW) begin
                errors++;
                $display("[TB] FAIL reset_low got=%b want=%b", {anL, segL, dpL, fsL}, RESET_LOW);
            end
            if ({anH, segH, dpH, fsH} !== 13'b0) begin
                errors++;
                $display("[TB] FAIL reset_high got=%b want=%b", {anH, segH, dpH, fsH}, 13'b0);
            end
        end
        digits_bcd = 16'h1234;
        reset      = 1'b0;
        pulsesL    = 0;
        pulsesH    = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            ex = model_pins(edges, (edges >= 5) ? 16'h1234 : 16'h0000, blank_lz, dp_pos);
            pulsesL += int'(fsL);
            pulsesH += int'(fsH);
            checks += 2;
            if ({anL, segL, dpL, fsL} !== {~ex[12:1], ex[0]}) begin
                errors++;
                $display("[TB] FAIL start_low e=%0d got=%b want=%b", edges, {anL, segL, dpL, fsL}, {~ex[12:1], ex[0]});
            end
            if ({anH, segH, dpH, fsH} !== ex) begin
                errors++;
                $display("[TB] FAIL start_high e=%0d got=%b want=%b", edges, {anH, segH, dpH, fsH}, ex);
            end
        end
        checks += 2;
        if (pulsesL !== 3) begin
            errors++;
            $display("[TB] FAIL frame_count_low got=%0d want=3", pulsesL);
        end
        if (pulsesH !== 3) begin
            errors++;
            $display("[TB] FAIL frame_count_high got=%0d want=3", pulsesH);
        end
        curV = 16'h1234;
    endtask

    task automatic test_scan_order();
        logic [12:0] ex;
        int swE;
        digits_bcd = 16'h9876;
        swE = edges + 5;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            ex = model_pins(edges, (edges >= swE) ? 16'h9876 : curV, blank_lz, dp_pos);
            checks += 2;
            if ({anL, segL, dpL, fsL} !== {~ex[12:1], ex[0]}) begin
                errors++;
                $display("[TB] FAIL order_low e=%0d got=%b want=%b", edges, {anL, segL, dpL, fsL}, {~ex[12:1], ex[0]});
            end
            if ({anH, segH, dpH, fsH} !== ex) begin
                errors++;
                $display("[TB] FAIL order_high e=%0d got=%b want=%b", edges, {anH, segH, dpH, fsH}, ex);
            end
        end
        curV = 16'h9876;
    endtask

    task automatic test_blanking();
        logic [15:0] vals [5] = '{16'h0005, 16'h0005, 16'h00A0, 16'h00A0, 16'h0000};
        logic        blzs [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0]  dps  [5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0100};
        logic [15:0] oldV;
        logic [12:0] ex;
        int swE;
        oldV = curV;
        for (int s = 0; s < 5; s++) begin
            digits_bcd = vals[s];
            blank_lz   = blzs[s];
            dp_pos     = dps[s];
            swE        = edges + 5;
            for (int c = 0; c < 24; c++) begin
                @(negedge clk);
                ex = model_pins(edges, (edges >= swE) ? vals[s] : oldV, blank_lz, dp_pos);
                checks += 2;
                if ({anL, segL, dpL, fsL} !== {~ex[12:1], ex[0]}) begin
                    errors++;
                    $display("[TB] FAIL blank_low step=%0d e=%0d got=%b want=%b", s, edges, {anL, segL, dpL, fsL}, {~ex[12:1], ex[0]});
                end
                if ({anH, segH, dpH, fsH} !== ex) begin
                    errors++;
                    $display("[TB] FAIL blank_high step=%0d e=%0d got=%b want=%b", s, edges, {anH, segH, dpH, fsH}, ex);
                end
            end
            oldV = vals[s];
        end
        blank_lz = 1'b0;
        dp_pos   = 4'b0000;
        curV     = oldV;
    endtask

    task automatic test_hold();
        logic [15:0] ins  [6] = '{16'h0100, 16'h0200, 16'h0200, 16'h0300, 16'h0300, 16'h0300};
        logic        hlds [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] news [6] = '{16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0300};
        int          offs [6] = '{5, 0, 2, 0, 0, 2};
        int          lens [6] = '{24, 40, 32, 2, 24, 24};
        logic [15:0] oldV;
        logic [12:0] ex;
        int swE;
        oldV = curV;
        for (int s = 0; s < 6; s++) begin
            digits_bcd = ins[s];
            hold       = hlds[s];
            swE        = edges + offs[s];
            for (int c = 0; c < lens[s]; c++) begin
                @(negedge clk);
                ex = model_pins(edges, (edges >= swE) ? news[s] : oldV, blank_lz, dp_pos);
                checks += 2;
                if ({anL, segL, dpL, fsL} !== {~ex[12:1], ex[0]}) begin
                    errors++;
                    $display("[TB] FAIL hold_low step=%0d e=%0d got=%b want=%b", s, edges, {anL, segL, dpL, fsL}, {~ex[12:1], ex[0]});
                end
                if ({anH, segH, dpH, fsH} !== ex) begin
                    errors++;
                    $display("[TB] FAIL hold_high step=%0d e=%0d got=%b want=%b", s, edges, {anH, segH, dpH, fsH}, ex);
                end
            end
            oldV = news[s];
        end
        curV = oldV;
    endtask

    task automatic test_glitch_latency();
        logic [15:0] ins  [7] = '{16'h0100, 16'h0109, 16'h0100, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        logic [15:0] news [7] = '{16'h0100, 16'h0100, 16'h0100, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        int          lens [7] = '{24, 1, 40, 21, 22, 23, 25};
        logic [15:0] oldV;
        logic [12:0] ex;
        int swE;
        oldV = curV;
        for (int s = 0; s < 7; s++) begin
            digits_bcd = ins[s];
            swE        = edges + 5;
            for (int c = 0; c < lens[s]; c++) begin
                @(negedge clk);
                ex = model_pins(edges, (edges >= swE) ? news[s] : oldV, blank_lz, dp_pos);
                checks += 2;
                if ({anL, segL, dpL, fsL} !== {~ex[12:1], ex[0]}) begin
                    errors++;
                    $display("[TB] FAIL glitch_low step=%0d e=%0d got=%b want=%b", s, edges, {anL, segL, dpL, fsL}, {~ex[12:1], ex[0]});
                end
                if ({anH, segH, dpH, fsH} !== ex) begin
                    errors++;
                    $display("[TB] FAIL glitch_high step=%0d e=%0d got=%b want=%b", s, edges, {anH, segH, dpH, fsH}, ex);
                end
            end
            oldV = news[s];
        end
        curV = oldV;
    endtask

    task automatic test_reset_midscan();
        logic [12:0] ex;
        digits_bcd = 16'h8888;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int phase = 0; phase < 2; phase++) begin
            reset = 1'b0;
            for (int c = 0; c < ((phase == 0) ? 11 : 24); c++) begin
                @(negedge clk);
                ex = model_pins(edges, (edges >= 5) ? 16'h8888 : 16'h0000, blank_lz, dp_pos);
                checks += 2;
                if ({anL, segL, dpL, fsL} !== {~ex[12:1], ex[0]}) begin
                    errors++;
                    $display("[TB] FAIL midscan_low ph=%0d e=%0d got=%b want=%b", phase, edges, {anL, segL, dpL, fsL}, {~ex[12:1], ex[0]});
                end
                if ({anH, segH, dpH, fsH} !== ex) begin
                    errors++;
                    $display("[TB] FAIL midscan_high ph=%0d e=%0d got=%b want=%b", phase, edges, {anH, segH, dpH, fsH}, ex);
                end
            end
            if (phase == 0) begin
                #2 reset = 1'b1;
                #1;
                checks += 2;
                if ({anL, segL, dpL, fsL} !== RESET_LOW) begin
                    errors++;
                    $display("[TB] FAIL async_reset_low got=%b want=%b", {anL, segL, dpL, fsL}, RESET_LOW);
                end
                if ({anH, segH, dpH, fsH} !== 13'b0) begin
                    errors++;
                    $display("[TB] FAIL async_reset_high got=%b want=%b", {anH, segH, dpH, fsH}, 13'b0);
                end
                @(negedge clk);
            end
        end
        curV = 16'h8888;
    endtask

    task automatic test_random();
        logic [15:0] oldV, newV;
        logic [12:0] ex;
        logic [3:0]  nib;
        int swE, len;
        oldV = curV;
        for (int it = 0; it < 10; it++) begin
            for (int d = 0; d < 4; d++) begin
                nib = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 0) nib = 4'd0;
                newV[4*d +: 4] = nib;
            end
            digits_bcd = newV;
            blank_lz   = 1'($urandom_range(0, 1));
            dp_pos     = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            swE        = edges + 5;
            len        = 20 + int'($urandom_range(0, 8));
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                ex = model_pins(edges, (edges >= swE) ? newV : oldV, blank_lz, dp_pos);
                checks += 2;
                if ({anL, segL, dpL, fsL} !== {~ex[12:1], ex[0]}) begin
                    errors++;
                    $display("[TB] FAIL random_low it=%0d e=%0d val=%h got=%b want=%b", it, edges, newV, {anL, segL, dpL, fsL}, {~ex[12:1], ex[0]});
                end
                if ({anH, segH, dpH, fsH} !== ex) begin
                    errors++;
                    $display("[TB] FAIL random_high it=%0d e=%0d val=%h got=%b want=%b", it, edges, newV, {anH, segH, dpH, fsH}, ex);
                end
            end
            oldV = newV;
        end
        curV = oldV;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_blanking();
        test_hold();
        test_glitch_latency();
        test_reset_midscan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
